// File: rtl/wots_gen_chain.sv
// WOTS chain iterator: applies thash_f `steps` times starting at chain position start_step.
// Optional busy-cycle profiling counter enabled by defining WOTS_CHAIN_CYCLE_CNT_EN.
module wots_gen_chain #(
  parameter int KEY_LEN    = 256,
  parameter int WOTS_W     = 16,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_LEN-1:0]    input_data,
  input  logic [KEY_LEN-1:0]    input_key,
  input  logic [255:0]          hash_addr,
  input  logic [STEP_WIDTH-1:0] start_step,
  input  logic [STEP_WIDTH-1:0] steps,
  output logic [KEY_LEN-1:0]    data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  thash_start,
  output logic [KEY_LEN-1:0]    thash_data_in,
  output logic [KEY_LEN-1:0]    thash_key,
  output logic [255:0]          thash_addr,
  input  logic [KEY_LEN-1:0]    thash_data_out,
  input  logic                  thash_done,
  output logic [31:0]           cycle_count
);

  localparam int IW = STEP_WIDTH + 1;
  // Keeps everything except the hash-address and keyAndMask words.
  localparam logic [255:0] ADDR_KEEP = {192'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'd0};

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [KEY_LEN-1:0]    value_q, key_q, data_out_q;
  logic [255:0]          addr_q;
  logic [IW-1:0]         i_q;
  logic [STEP_WIDTH-1:0] rem_q;
  logic                  accept;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      // i is one bit wider than the step fields so it can reach WOTS_W without wrapping.
      S_CHECK: state_d = ((rem_q == '0) || (i_q >= IW'(WOTS_W))) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (thash_done) state_d = S_CHECK;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      value_q    <= '0;
      key_q      <= '0;
      addr_q     <= '0;
      i_q        <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        value_q <= input_data;
        key_q   <= input_key;
        addr_q  <= hash_addr;
        i_q     <= IW'(start_step);
        rem_q   <= steps;
      end
      if ((state_q == S_WAIT) && thash_done) begin
        value_q <= thash_data_out;
        i_q     <= i_q + IW'(1);
        rem_q   <= rem_q - STEP_WIDTH'(1);
      end
      if ((state_q == S_CHECK) && (state_d == S_DONE))
        data_out_q <= value_q;
    end
  end

  assign busy          = (state_q == S_CHECK) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done          = (state_q == S_DONE);
  assign thash_start   = (state_q == S_ISSUE);
  assign data_out      = data_out_q;
  assign thash_data_in = value_q;
  assign thash_key     = key_q;
  assign thash_addr    = (addr_q & ADDR_KEEP) | {192'd0, 32'(i_q), 32'd0};

`ifdef WOTS_CHAIN_CYCLE_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (busy)   cnt_q <= cnt_q + 32'd1;
  end
  assign cycle_count = cnt_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule
